phase_to_amplitude_qw: RTL and testbench

PHASE_TO_AMPLITUDE_QW -- requirements
Module: phase_to_amplitude_qw

---
 rtl/phase_to_amplitude_qw.sv | 108 ++++++++++
 tb/tb_phase_to_amplitude_qw.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_to_amplitude_qw.sv
// Phase word to signed sine/cosine via one shared quarter-wave ROM.
// Three registered stages (phase add, ROM read, sign apply); no back-pressure.
module phase_to_amplitude_qw #(
  parameter int PHASE_BITS = 32,
  parameter int ADDR_BITS  = 10,
  parameter int AMP_BITS   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PHASE_BITS-1:0]      phase_in,
  input  logic                       phase_valid,
  input  logic [PHASE_BITS-1:0]      offset_in,
  input  logic                       offset_load,
  output logic signed [AMP_BITS-1:0] sine_out,
  output logic signed [AMP_BITS-1:0] cosine_out,
  output logic                       amp_valid
);

  localparam int     DEPTH   = 1 << ADDR_BITS;
  localparam int     FRAC    = 56;
  localparam longint AMP_MAX = (64'sd1 <<< (AMP_BITS - 1)) - 64'sd1;
  localparam logic signed [127:0] HALF_PI_FX = 128'sh0192_1FB5_4442_D184;

  // Elaboration-time sine via Taylor series in Q71.56 fixed point, rounded to nearest.
  function automatic logic [AMP_BITS-1:0] qw_entry(input int k);
    logic signed [127:0] x, x2, term, sum;
    x    = (HALF_PI_FX * $signed(128'(2 * k + 1))) / $signed(128'(2 * DEPTH));
    x2   = (x * x) >>> FRAC;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> FRAC) / $signed(128'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    sum = (sum * $signed(128'(AMP_MAX)) + (128'sd1 <<< (FRAC - 1))) >>> FRAC;
    return sum[AMP_BITS-1:0];
  endfunction

  logic [AMP_BITS-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [AMP_BITS-1:0] ENTRY = qw_entry(k);
    assign rom[k] = ENTRY;
  end

  logic [PHASE_BITS-1:0] offset_reg;
  logic [PHASE_BITS-1:0] p1;
  logic                  v1;
  logic [AMP_BITS-1:0]   mag_s, mag_c;
  logic                  neg_s, neg_c;
  logic                  v2;

  logic [1:0]            q_s, q_c;
  logic [ADDR_BITS-1:0]  a1, addr_s, addr_c;

  assign q_s = p1[PHASE_BITS-1 -: 2];
  assign q_c = q_s + 2'd1;
  assign a1  = p1[PHASE_BITS-3 -: ADDR_BITS];

  // Odd quadrants walk the quarter wave backwards (mirror index).
  assign addr_s = q_s[0] ? ~a1 : a1;
  assign addr_c = q_c[0] ? ~a1 : a1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset_reg <= '0;
      p1         <= '0;
      v1         <= 1'b0;
    end else begin
      if (offset_load) offset_reg <= offset_in;
      v1 <= phase_valid;
      if (phase_valid) p1 <= phase_in + offset_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_s <= '0;
      mag_c <= '0;
      neg_s <= 1'b0;
      neg_c <= 1'b0;
      v2    <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        mag_s <= rom[addr_s];
        mag_c <= rom[addr_c];
        neg_s <= q_s[1];
        neg_c <= q_c[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sine_out   <= '0;
      cosine_out <= '0;
      amp_valid  <= 1'b0;
    end else begin
      amp_valid <= v2;
      if (v2) begin
        sine_out   <= neg_s ? -$signed(mag_s) : $signed(mag_s);
        cosine_out <= neg_c ? -$signed(mag_c) : $signed(mag_c);
      end
    end
  end

endmodule

// File: tb/tb_phase_to_amplitude_qw.sv
// Scoreboard bench: stimulus pushes expected samples, a monitor pops on amp_valid.
module tb_phase_to_amplitude_qw;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        phase_in = '0;
  logic               phase_valid = 1'b0;
  logic [31:0]        offset_in = '0;
  logic               offset_load = 1'b0;
  logic signed [15:0] sine_out;
  logic signed [15:0] cosine_out;
  logic               amp_valid;

  phase_to_amplitude_qw #(.PHASE_BITS(32), .ADDR_BITS(10), .AMP_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .phase_in(phase_in), .phase_valid(phase_valid),
    .offset_in(offset_in), .offset_load(offset_load),
    .sine_out(sine_out), .cosine_out(cosine_out), .amp_valid(amp_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    es;
    int    ec;
    int    acc;
    bit    mag;
    string nm;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    cyc = 0;
  int    checks = 0;
  int    passed = 0;
  int    last_s = 0;
  int    last_c = 0;

  localparam longint FULL2 = 64'd1073676289;  // 32767^2
  localparam longint TOL   = 64'd1073676;     // 0.1 %

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rom_m(input int k);
    real r;
    r = 32767.0 * $sin(2.0 * 3.141592653589793 * (real'(k) + 0.5) / 4096.0);
    return int'($floor(r + 0.5));
  endfunction

  function automatic int amp_m(input int qq, input int a);
    case (qq)
      0:       return  rom_m(a);
      1:       return  rom_m(1023 - a);
      2:       return -rom_m(a);
      default: return -rom_m(1023 - a);
    endcase
  endfunction

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", nm, got, req);
  endtask

  // Monitor: every amp_valid pops one expectation; idle cycles must hold the last sample.
  always begin
    longint m;
    bit ok;
    @(posedge clk);
    #1;
    if (rst) begin
      if (amp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL spurious_amp_valid: got amp_valid=1, required no pending sample");
        end else begin
          mon_e = sb.pop_front();
          m  = longint'(sine_out) * longint'(sine_out) + longint'(cosine_out) * longint'(cosine_out);
          ok = (int'(sine_out) == mon_e.es) && (int'(cosine_out) == mon_e.ec) && (cyc - mon_e.acc == 3);
          if (mon_e.mag && ((m > FULL2 + TOL) || (m + TOL < FULL2))) ok = 1'b0;
          if (ok) passed++;
          else $display("FAIL %s: got sin=%0d cos=%0d lat=%0d mag2=%0d, required sin=%0d cos=%0d lat=3",
                        mon_e.nm, sine_out, cosine_out, cyc - mon_e.acc, m, mon_e.es, mon_e.ec);
          last_s = mon_e.es;
          last_c = mon_e.ec;
        end
      end else begin
        checks++;
        if (int'(sine_out) == last_s && int'(cosine_out) == last_c) passed++;
        else $display("FAIL hold: got sin=%0d cos=%0d, required sin=%0d cos=%0d",
                      sine_out, cosine_out, last_s, last_c);
      end
    end
  end

  task automatic issue(input logic [31:0] ph, input bit vld, input bit ld, input logic [31:0] off,
                       input int es, input int ec, input bit mag, input bit push, input string nm);
    exp_t e;
    @(negedge clk);
    phase_in    = ph;
    phase_valid = vld;
    offset_in   = off;
    offset_load = ld;
    @(posedge clk);
    if (vld && push) begin
      e.es = es; e.ec = ec; e.acc = cyc; e.mag = mag; e.nm = nm;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) issue(32'h0, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, "");
  endtask

  function automatic int sin_of(input logic [31:0] p);
    return amp_m(int'(p[31:30]), int'(p[29:20]));
  endfunction

  function automatic int cos_of(input logic [31:0] p);
    return amp_m((int'(p[31:30]) + 1) % 4, int'(p[29:20]));
  endfunction

  initial begin
    logic [31:0] ph;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_amp_valid", int'(amp_valid), 0);
    chk("reset_sine", int'(sine_out), 0);
    chk("reset_cosine", int'(cosine_out), 0);
    @(negedge clk);
    rst = 1'b1;

    // Quadrant corners, boundary address and truncated LSBs, back to back
    issue(32'h0000_0000, 1, 0, 0,     25,  32767, 0, 1, "phase_0");
    idle(4);
    issue(32'h4000_0000, 1, 0, 0,  32767,    -25, 0, 1, "phase_40");
    issue(32'h8000_0000, 1, 0, 0,    -25, -32767, 0, 1, "phase_80");
    issue(32'hC000_0000, 1, 0, 0, -32767,     25, 0, 1, "phase_c0");
    issue(32'h3FFF_FFFF, 1, 0, 0,  32767,     25, 0, 1, "phase_3fff");
    issue(32'h000F_FFFF, 1, 0, 0,     25,  32767, 0, 1, "trunc_lsb");
    issue(32'hBFFF_FFFF, 1, 0, 0, -32767,    -25, 0, 1, "phase_bfff");
    idle(4);

    // Offset wrap: 0xC000_0000 + 0x4000_0000 -> 0
    issue(32'h0, 0, 1, 32'h4000_0000, 0, 0, 0, 0, "");
    issue(32'hC000_0000, 1, 0, 0, 25, 32767, 0, 1, "offset_wrap");
    idle(2);

    // Same-cycle load uses the old offset; the next sample sees the new one
    issue(32'h0, 0, 1, 32'h0, 0, 0, 0, 0, "");
    issue(32'h0, 1, 1, 32'h8000_0000,  25,  32767, 0, 1, "load_same_cycle");
    issue(32'h0, 1, 0, 0,             -25, -32767, 0, 1, "load_next_sample");
    issue(32'h4000_0000, 1, 0, 0,  -32767,     25, 0, 1, "inflight_old_off");
    issue(32'h0, 0, 1, 32'h0, 0, 0, 0, 0, "");
    issue(32'h4000_0000, 1, 0, 0,   32767,    -25, 0, 1, "new_off_zero");
    idle(4);

    // Mid-stream reset with samples in flight; offset left non-zero to prove it clears
    issue(32'h0, 0, 1, 32'h8000_0000, 0, 0, 0, 0, "");
    idle(4);
    issue(32'h4000_0000, 1, 0, 0, 0, 0, 0, 0, "");
    issue(32'h8000_0000, 1, 0, 0, 0, 0, 0, 0, "");
    @(negedge clk);
    phase_in = 32'hC000_0000;
    rst = 1'b0;
    last_s = 0;
    last_c = 0;
    #1;
    chk("midrst_amp_valid", int'(amp_valid), 0);
    chk("midrst_sine", int'(sine_out), 0);
    chk("midrst_cosine", int'(cosine_out), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("inrst_amp_valid", int'(amp_valid), 0);
      chk("inrst_sine", int'(sine_out), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    phase_valid = 1'b0;
    idle(2);
    issue(32'h0, 1, 0, 0, 25, 32767, 0, 1, "post_reset");
    idle(4);

    // Coarse sweep through all four quadrants
    for (int i = 0; i < 64; i++) begin
      ph = 32'(i) * 32'h0400_0000 + 32'h0012_3456;
      issue(ph, 1, 0, 0, sin_of(ph), cos_of(ph), 1, 1, "sweep");
    end
    idle(2);

    // Continuous accumulator stream
    for (int i = 0; i < 4200; i++) begin
      ph = 32'(i) * 32'h0001_0001;
      issue(ph, 1, 0, 0, sin_of(ph), cos_of(ph), 1, 1, "stream");
    end
    @(negedge clk);
    phase_valid = 1'b0;

    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending samples, required 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
